mem_req_scheduler: RTL and testbench

MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

---
 rtl/mem_req_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_req_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler: in-order DRAM request scheduler with a request FIFO,
// per-bank open-page tracking and a PRE/ACT/RW command sequencer.
// Define SCHED_STATS_EN to add the stat_hits/stat_misses counters and ports.
module mem_req_scheduler #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 36,
    parameter int TIME_WIDTH = 32,
    parameter int T_RP       = 4,
    parameter int T_RCD      = 4,
    parameter int T_CL       = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TIME_WIDTH-1:0]  in_time,
    input  logic [1:0]             in_op,
    input  logic [ADDR_WIDTH-1:0]  in_addr,
    output logic                   ord_err,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [2:0]             cmd_type,
    output logic [1:0]             cmd_bank,
    output logic [15:0]            cmd_row,
    output logic [11:0]            cmd_col,
    output logic                   done_valid,
    output logic [1:0]             done_op,
    output logic [ADDR_WIDTH-1:0]  done_addr,
    output logic [$clog2(DEPTH):0] q_count
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]            stat_hits,
    output logic [15:0]            stat_misses
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = 8;

    localparam logic [2:0] CMD_PRE = 3'd1;
    localparam logic [2:0] CMD_ACT = 3'd2;
    localparam logic [2:0] CMD_RD  = 3'd3;
    localparam logic [2:0] CMD_WR  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_RW, S_RW_WAIT, S_DONE
    } state_e;

    // request FIFO storage (data path only, no reset needed)
    logic [TIME_WIDTH-1:0] q_time_q [DEPTH];
    logic [1:0]            q_op_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr_q [DEPTH];

    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [TIME_WIDTH-1:0] cpu_time_q, last_time_q;
    logic                  ord_err_q;

    state_e                state_q;
    logic [WW-1:0]         wait_q;
    logic                  cmd_valid_q, done_valid_q;
    logic [2:0]            cmd_type_q;
    logic [1:0]            done_op_q;
    logic [ADDR_WIDTH-1:0] done_addr_q;
    logic [3:0]            bank_open_q;
    logic [3:0][15:0]      bank_row_q;

    logic                  hs, enq, deq, head_elig, row_hit;
    logic [TIME_WIDTH-1:0] head_time;
    logic [1:0]            head_op;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [1:0]            head_bank;
    logic [15:0]           head_row;
    logic [2:0]            rw_type;

    assign head_time = q_time_q[rd_ptr_q];
    assign head_op   = q_op_q[rd_ptr_q];
    assign head_addr = q_addr_q[rd_ptr_q];
    assign head_bank = head_addr[19:18];
    assign head_row  = head_addr[35:20];
    assign rw_type   = (head_op == 2'd1) ? CMD_WR : CMD_RD;
    assign row_hit   = bank_open_q[head_bank] && (bank_row_q[head_bank] == head_row);
    assign head_elig = (count_q != '0) && (cpu_time_q >= head_time);

    // a full queue keeps in_ready low even while the head retires
    assign in_ready = (count_q < CW'(DEPTH));
    assign hs       = in_valid && in_ready;
    assign enq      = hs && !(in_time < last_time_q);
    assign deq      = (state_q == S_DONE);

    // FIFO payload write
    always_ff @(posedge clk) begin
        if (enq) begin
            q_time_q[wr_ptr_q] <= in_time;
            q_op_q[wr_ptr_q]   <= in_op;
            q_addr_q[wr_ptr_q] <= in_addr;
        end
    end

    // FIFO pointers/occupancy, time-order filter and the free-running cpu clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cpu_time_q  <= '0;
            last_time_q <= '0;
            ord_err_q   <= 1'b0;
        end else begin
            if (cpu_time_q != '1) cpu_time_q <= cpu_time_q + TIME_WIDTH'(1);
            ord_err_q <= hs && (in_time < last_time_q);
            if (enq) begin
                wr_ptr_q    <= wr_ptr_q + PW'(1);
                last_time_q <= in_time;
            end
            if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({enq, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // command sequencer with registered command/completion outputs and bank state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_type_q   <= '0;
            done_valid_q <= 1'b0;
            done_op_q    <= '0;
            done_addr_q  <= '0;
            bank_open_q  <= '0;
            bank_row_q   <= '0;
        end else begin
            done_valid_q <= 1'b0;
            done_op_q    <= '0;
            done_addr_q  <= '0;
            case (state_q)
                S_IDLE: if (head_elig) begin
                    cmd_valid_q <= 1'b1;
                    if (row_hit) begin
                        state_q    <= S_RW;
                        cmd_type_q <= rw_type;
                    end else if (bank_open_q[head_bank]) begin
                        state_q    <= S_PRE;
                        cmd_type_q <= CMD_PRE;
                    end else begin
                        state_q    <= S_ACT;
                        cmd_type_q <= CMD_ACT;
                    end
                end
                S_PRE: if (cmd_ready) begin
                    cmd_valid_q            <= 1'b0;
                    cmd_type_q             <= '0;
                    bank_open_q[head_bank] <= 1'b0;
                    wait_q                 <= WW'(T_RP - 1);
                    state_q                <= S_PRE_WAIT;
                end
                S_PRE_WAIT: if (wait_q == '0) begin
                    state_q     <= S_ACT;
                    cmd_valid_q <= 1'b1;
                    cmd_type_q  <= CMD_ACT;
                end else wait_q <= wait_q - WW'(1);
                S_ACT: if (cmd_ready) begin
                    cmd_valid_q            <= 1'b0;
                    cmd_type_q             <= '0;
                    bank_open_q[head_bank] <= 1'b1;
                    bank_row_q[head_bank]  <= head_row;
                    wait_q                 <= WW'(T_RCD - 1);
                    state_q                <= S_ACT_WAIT;
                end
                S_ACT_WAIT: if (wait_q == '0) begin
                    state_q     <= S_RW;
                    cmd_valid_q <= 1'b1;
                    cmd_type_q  <= rw_type;
                end else wait_q <= wait_q - WW'(1);
                S_RW: if (cmd_ready) begin
                    cmd_valid_q <= 1'b0;
                    cmd_type_q  <= '0;
                    wait_q      <= WW'(T_CL - 1);
                    state_q     <= S_RW_WAIT;
                end
                S_RW_WAIT: if (wait_q == '0) begin
                    state_q      <= S_DONE;
                    done_valid_q <= 1'b1;
                    done_op_q    <= head_op;
                    done_addr_q  <= head_addr;
                end else wait_q <= wait_q - WW'(1);
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] hits_q, misses_q;

    // count IDLE scheduling decisions by page outcome, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state_q == S_IDLE && head_elig) begin
            if (row_hit) begin
                if (hits_q != '1) hits_q <= hits_q + 16'd1;
            end else begin
                if (misses_q != '1) misses_q <= misses_q + 16'd1;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

    // command fields follow the head entry and read as zero when idle
    assign cmd_valid  = cmd_valid_q;
    assign cmd_type   = cmd_type_q;
    assign cmd_bank   = cmd_valid_q ? head_bank : '0;
    assign cmd_row    = cmd_valid_q ? head_row : '0;
    assign cmd_col    = cmd_valid_q ? head_addr[17:6] : '0;
    assign done_valid = done_valid_q;
    assign done_op    = done_op_q;
    assign done_addr  = done_addr_q;
    assign ord_err    = ord_err_q;
    assign q_count    = count_q;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Bench for mem_req_scheduler: table of requests with expected command
// sequences feeding a scoreboard, plus hand sequences for latency,
// time-order drop, full queue and mid-command reset.
module tb_mem_req_scheduler;
    localparam logic [2:0] PRE = 3'd1, ACT = 3'd2, RD = 3'd3, WR = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_time;
    logic [1:0]  in_op;
    logic [35:0] in_addr;
    logic        ord_err, cmd_valid, cmd_ready;
    logic [2:0]  cmd_type;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [11:0] cmd_col;
    logic        done_valid;
    logic [1:0]  done_op;
    logic [35:0] done_addr;
    logic [4:0]  q_count;
`ifdef SCHED_STATS_EN
    logic [15:0] stat_hits, stat_misses;
`endif

    mem_req_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time),
        .in_op(in_op), .in_addr(in_addr), .ord_err(ord_err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .done_valid(done_valid), .done_op(done_op), .done_addr(done_addr),
        .q_count(q_count)
`ifdef SCHED_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] t;
        logic [1:0]  op;
        logic [35:0] addr;
        logic [2:0]  c0, c1, c2;
    } vec_t;
    typedef struct { logic [2:0] typ; logic [35:0] addr; } cmd_e;
    typedef struct { logic [1:0] op;  logic [35:0] addr; } done_e;

    cmd_e  cmd_q[$];
    done_e done_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic expect_req(input logic [1:0] op, input logic [35:0] a,
                              input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2);
        cmd_e  c;
        done_e d;
        c.addr = a;
        if (c0 != 0) begin c.typ = c0; cmd_q.push_back(c); end
        if (c1 != 0) begin c.typ = c1; cmd_q.push_back(c); end
        if (c2 != 0) begin c.typ = c2; cmd_q.push_back(c); end
        d.op = op; d.addr = a;
        done_q.push_back(d);
    endtask

    // scoreboard: compare every command handshake and completion pulse
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (cmd_valid && cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_cmd: got type %0d, expected none", cmd_type);
                end else begin
                    cmd_e e;
                    e = cmd_q.pop_front();
                    chk("cmd", {cmd_type, cmd_bank, cmd_row, cmd_col},
                        {e.typ, e.addr[19:18], e.addr[35:20], e.addr[17:6]});
                end
            end
            if (done_valid) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got addr %0h, expected none", done_addr);
                end else begin
                    done_e e;
                    e = done_q.pop_front();
                    chk("done", {done_op, done_addr}, {e.op, e.addr});
                end
            end
        end
    end

    // called negedge-aligned or just after a posedge; returns just after the accepting edge
    task automatic push(input logic [31:0] t, input logic [1:0] op, input logic [35:0] a);
        int n = 0;
        in_valid = 1'b1; in_time = t; in_op = op; in_addr = a;
        while (!in_ready && n < 400) begin @(negedge clk); n++; end
        chk("in_accept", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while ((cmd_q.size() != 0 || done_q.size() != 0) && n < bound) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        #2 chk(name, cmd_q.size() + done_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; cmd_ready = 1'b0;
        cmd_q.delete(); done_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [35:0] A;
        int kc, kd, n;
        bit seen_done, acc;

        // bank 0 row 1 col 1 (address bit 20 selects row bit 0)
        A = 36'h0_0010_0040;
        vecs[0] = '{t: 0,   op: 2'd0, addr: 36'h0_0010_0040, c0: ACT, c1: RD,  c2: 0};
        vecs[1] = '{t: 0,   op: 2'd0, addr: 36'h0_0010_0080, c0: RD,  c1: 0,   c2: 0};
        vecs[2] = '{t: 5,   op: 2'd1, addr: 36'h0_0020_00C0, c0: PRE, c1: ACT, c2: WR};
        vecs[3] = '{t: 5,   op: 2'd2, addr: 36'h0_0054_01C0, c0: ACT, c1: RD,  c2: 0};
        vecs[4] = '{t: 100, op: 2'd1, addr: 36'h0_0054_0000, c0: WR,  c1: 0,   c2: 0};
        vecs[5] = '{t: 100, op: 2'd0, addr: 36'hF_FFFF_FFC0, c0: ACT, c1: RD,  c2: 0};
        vecs[6] = '{t: 100, op: 2'd0, addr: 36'h0_0020_0000, c0: RD,  c1: 0,   c2: 0};

        in_valid = 1'b0; in_time = '0; in_op = '0; in_addr = '0; cmd_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_q_count", q_count, 0);
        chk("rst_cmd", {cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col}, 0);
        chk("rst_done", {done_valid, done_op, done_addr, ord_err}, 0);
        do_reset();

        // table: open-page hits, misses, conflicts, ops and time gating
        cmd_ready = 1'b1;
        foreach (vecs[i]) begin
            expect_req(vecs[i].op, vecs[i].addr, vecs[i].c0, vecs[i].c1, vecs[i].c2);
            push(vecs[i].t, vecs[i].op, vecs[i].addr);
        end
        drain("table_drain", 800);
`ifdef SCHED_STATS_EN
        chk("stat_hits", stat_hits, 3);
        chk("stat_misses", stat_misses, 4);
`endif

        // row-hit latency: eligible in cycle k=0, command at k=1, done at k=2+T_CL
        expect_req(2'd0, 36'h0_0020_0000, RD, 0, 0);
        push(100, 2'd0, 36'h0_0020_0000);
        kc = -1; kd = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cmd_valid && kc < 0) kc = k;
            if (done_valid && kd < 0) kd = k;
        end
        chk("hit_cmd_latency", kc, 1);
        chk("hit_done_latency", kd, 8);
        drain("latency_drain", 50);

        // time going backwards is dropped with a one-cycle ord_err
        do_reset();
        push(10, 2'd0, A);
        @(negedge clk);
        chk("order_ok_err", ord_err, 1'b0);
        chk("order_ok_count", q_count, 1);
        push(5, 2'd0, A);
        @(negedge clk);
        chk("order_drop_err", ord_err, 1'b1);
        chk("order_drop_count", q_count, 1);
        @(negedge clk);
        chk("order_err_pulse", ord_err, 1'b0);

        // fill to 16 with commands stalled, 17th waits for the first retire
        do_reset();
        expect_req(2'd0, A, ACT, RD, 0);
        push(0, 2'd0, A);
        for (int i = 1; i < 16; i++) begin
            expect_req(2'd0, A, RD, 0, 0);
            push(0, 2'd0, A);
        end
        @(negedge clk);
        chk("full_count", q_count, 16);
        chk("full_in_ready", in_ready, 1'b0);
        repeat (3) @(negedge clk);
        chk("full_hold_count", q_count, 16);
        expect_req(2'd0, A, RD, 0, 0);
        in_valid = 1'b1; in_time = '0; in_op = 2'd0; in_addr = A;
        cmd_ready = 1'b1;
        seen_done = 0; acc = 0; n = 0;
        while (!acc && n < 300) begin
            if (done_valid && !seen_done) begin
                seen_done = 1;
                chk("full_retire_in_ready", in_ready, 1'b0);
            end
            if (in_ready) acc = 1;
            else begin @(negedge clk); n++; end
        end
        chk("accept_after_retire", {acc, seen_done}, 2'b11);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("refill_count", q_count, 16);
        drain("full_drain", 1000);

        // reset during ACT_WAIT abandons the request; next one starts with ACT again
        do_reset();
        cmd_ready = 1'b1;
        expect_req(2'd0, A, ACT, RD, 0);
        push(0, 2'd0, A);
        n = 0;
        @(negedge clk);
        while (!(cmd_valid && cmd_type == ACT) && n < 50) begin @(negedge clk); n++; end
        chk("act_issued", (n < 50), 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        cmd_q.delete(); done_q.delete();
        #1;
        chk("midrst_count", q_count, 0);
        chk("midrst_outputs", {cmd_valid, cmd_type, done_valid, ord_err}, 0);
        chk("midrst_in_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_req(2'd1, A, ACT, WR, 0);
        push(0, 2'd1, A);
        drain("midrst_drain", 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
